vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing.sv | 47 ++++
 rtl/vga_scanout.sv | 197 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, region encoding and colour expansion for the VGA scanout.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int          VGA_CLK_DIV = 2;
   localparam logic [31:0] VGA_FB_BASE = 32'h100;
   localparam int          VGA_FB_W    = 32;
   localparam int          VGA_FB_H    = 24;
   localparam int          VGA_SCALE   = 20;

   typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} h_region_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // RRRGGGBB -> 4 bits per channel by replicating the top bits into the gaps
   function automatic rgb444_t rgb332_to_444(input logic [7:0] p);
      rgb444_t c;
      c.r = {p[7:5], p[7]};
      c.g = {p[4:2], p[4]};
      c.b = {p[1:0], p[1:0]};
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// One display axis: wrapping position counter with active/front/sync/back region decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int N_ACTIVE = 640,
   parameter int N_FP     = 16,
   parameter int N_SYNC   = 96,
   parameter int N_BP     = 48,
   parameter int W        = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         cin,
   output logic [W-1:0] count,
   output h_region_t    region,
   output logic         sync_n,
   output logic         wrap
);

   localparam int N_TOTAL = N_ACTIVE + N_FP + N_SYNC + N_BP;

   assign wrap = en && cin && (count == W'(N_TOTAL - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (en && cin) begin
         if (wrap) count <= '0;
         else      count <= count + 1'b1;
      end
   end

   always_comb begin
      if (count < W'(N_ACTIVE))
         region = ACTIVE;
      else if (count < W'(N_ACTIVE + N_FP))
         region = FRONT;
      else if (count < W'(N_ACTIVE + N_FP + N_SYNC))
         region = SYNC;
      else
         region = BACK;
   end

   assign sync_n = (region != SYNC);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer-to-VGA reader: pixel-rate timing, upscaled address generation and a
// one-pixel-period registered output stage producing RGB444 with aligned syncs.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int          CLK_DIV  = VGA_CLK_DIV,
   parameter int          H_ACTIVE = VGA_H_ACTIVE,
   parameter int          H_FP     = VGA_H_FP,
   parameter int          H_SYNC   = VGA_H_SYNC,
   parameter int          H_BP     = VGA_H_BP,
   parameter int          V_ACTIVE = VGA_V_ACTIVE,
   parameter int          V_FP     = VGA_V_FP,
   parameter int          V_SYNC   = VGA_V_SYNC,
   parameter int          V_BP     = VGA_V_BP,
   parameter logic [31:0] FB_BASE  = VGA_FB_BASE,
   parameter int          FB_W     = VGA_FB_W,
   parameter int          FB_H     = VGA_FB_H,
   parameter int          SCALE    = VGA_SCALE
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] va,
   input  logic [31:0] vd,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        de,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = $clog2(CLK_DIV);
   localparam int SW      = $clog2(SCALE + 1);
   localparam int FXW     = $clog2(FB_W + 1);
   localparam int FYW     = $clog2(FB_H + 1);

   logic [DW-1:0] div;
   logic          pix_en;

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   h_region_t     h_region, v_region;
   logic          h_sync_n, v_sync_n;
   logic          h_wrap, v_wrap;

   logic [SW-1:0]  sx, sx_n, sy, sy_n;
   logic [FXW-1:0] fx, fx_n;
   logic [FYW-1:0] fy, fy_n;
   logic [31:0]    row_base, row_n, va_n;
   logic           h_act_nxt, v_act_nxt;

   logic [7:0] pix_byte;
   rgb444_t    rgb;
   logic       act;

   assign pix_en = (div == DW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    div <= '0;
      else if (pix_en) div <= '0;
      else             div <= div + 1'b1;
   end

   vga_timing #(
      .N_ACTIVE (H_ACTIVE),
      .N_FP     (H_FP),
      .N_SYNC   (H_SYNC),
      .N_BP     (H_BP),
      .W        (HW)
   ) u_htiming (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (pix_en),
      .cin     (1'b1),
      .count   (hcnt),
      .region  (h_region),
      .sync_n  (h_sync_n),
      .wrap    (h_wrap)
   );

   vga_timing #(
      .N_ACTIVE (V_ACTIVE),
      .N_FP     (V_FP),
      .N_SYNC   (V_SYNC),
      .N_BP     (V_BP),
      .W        (VW)
   ) u_vtiming (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (pix_en),
      .cin     (h_wrap),
      .count   (vcnt),
      .region  (v_region),
      .sync_n  (v_sync_n),
      .wrap    (v_wrap)
   );

   // Next-state of the scale counters is computed for the pixel the counters are
   // about to move to, so va lands on the same edge as the new hcnt/vcnt.
   always_comb begin
      h_act_nxt = h_wrap || (hcnt < HW'(H_ACTIVE - 1));
      if (h_wrap) v_act_nxt = v_wrap || (vcnt < VW'(V_ACTIVE - 1));
      else        v_act_nxt = (v_region == ACTIVE);

      sx_n = '0;
      fx_n = '0;
      if (h_act_nxt && v_act_nxt && !h_wrap) begin
         if (sx == SW'(SCALE - 1)) begin
            fx_n = fx + 1'b1;
         end else begin
            sx_n = sx + 1'b1;
            fx_n = fx;
         end
      end

      // Vertical position advances as the line enters blanking, so the blanking
      // interval already points at the start of the following line.
      sy_n  = sy;
      fy_n  = fy;
      row_n = row_base;
      if (hcnt == HW'(H_ACTIVE - 1)) begin
         if (vcnt < VW'(V_ACTIVE - 1)) begin
            if (sy == SW'(SCALE - 1)) begin
               sy_n  = '0;
               fy_n  = fy + 1'b1;
               row_n = row_base + 32'(FB_W);
            end else begin
               sy_n = sy + 1'b1;
            end
         end else begin
            sy_n  = '0;
            fy_n  = '0;
            row_n = '0;
         end
      end

      va_n = FB_BASE + row_n + 32'(fx_n);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sx       <= '0;
         fx       <= '0;
         sy       <= '0;
         fy       <= '0;
         row_base <= '0;
         va       <= FB_BASE;
      end else if (pix_en) begin
         sx       <= sx_n;
         fx       <= fx_n;
         sy       <= sy_n;
         fy       <= fy_n;
         row_base <= row_n;
         va       <= va_n;
      end
   end

   // Little-endian lane select, matching the CPU byte-write lanes
   always_comb begin
      case (va[1:0])
         2'd0:    pix_byte = vd[7:0];
         2'd1:    pix_byte = vd[15:8];
         2'd2:    pix_byte = vd[23:16];
         default: pix_byte = vd[31:24];
      endcase
   end

   assign act = (h_region == ACTIVE) && (v_region == ACTIVE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_en && (hcnt == '0) && (vcnt == '0);
         if (pix_en) begin
            hsync <= h_sync_n;
            vsync <= v_sync_n;
            de    <= act;
            rgb   <= act ? rgb332_to_444(pix_byte) : '0;
         end
      end
   end

   assign vga_r = rgb.r;
   assign vga_g = rgb.g;
   assign vga_b = rgb.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a shrunken raster (64x48 visible, scale 2).
module tb_vga_scanout;

   localparam int CD  = 2;
   localparam int HA  = 64, HFP = 4, HS = 8, HBP = 4;
   localparam int VA  = 48, VFP = 2, VS = 2, VBP = 3;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FBW = 32, FBH = 24, S = 2;
   localparam logic [31:0] BASE = 32'h100;
   localparam int FRAME_CLK = HT * VT * CD;
   localparam int NVEC = 16;

   logic        clk;
   logic        reset_n;
   logic [31:0] va, vd;
   logic        hsync, vsync, de, frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;

   int n_cmp = 0;
   int n_bad = 0;
   logic in_blank;

   vga_scanout #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .FB_BASE(BASE), .FB_W(FBW), .FB_H(FBH), .SCALE(S)
   ) dut (
      .clk(clk), .reset_n(reset_n), .va(va), .vd(vd),
      .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .de(de), .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] wa;
      logic [7:0]  w;
      wa = a >> 2;
      w  = wa[7:0];
      if (wa == (BASE >> 2)) return 32'h03E01CFF;
      return {w ^ 8'h5A, w + 8'h33, ~w, w};
   endfunction

   // Video port: one-clock read latency, all ones while the raster is blanked
   always @(posedge clk) vd <= in_blank ? 32'hFFFF_FFFF : word_at(va);

   typedef struct {
      int          h;
      int          v;
      logic [31:0] va;
      logic        chk_rgb;
      logic [11:0] rgb;
      logic        de;
   } vec_t;

   typedef struct {
      int          ph;
      int          pv;
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [11:0] rgb;
      int          tbl;
   } exp_t;

   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic int find_vec(input int h, input int v);
      for (int i = 0; i < NVEC; i++)
         if (vecs[i].h == h && vecs[i].v == v) return i;
      return -1;
   endfunction

   function automatic logic [31:0] exp_addr(input int h, input int v);
      if (h < HA && v < VA) return BASE + 32'((v / S) * FBW + h / S);
      if (h >= HA && v + 1 < VA) return BASE + 32'(((v + 1) / S) * FBW);
      return BASE;
   endfunction

   function automatic logic [11:0] expand(input logic [7:0] p);
      return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
   endfunction

   // Sync/enable timing monitor, stepped once per clock from the scoreboard loop
   int   cyc, hf_t, vf_t, fs_t, de_t;
   logic hf_ok, vf_ok, fs_ok, de_ok, p_hs, p_vs, p_de;

   task automatic mon_clear();
      hf_ok = 0; vf_ok = 0; fs_ok = 0; de_ok = 0;
      p_hs = 1; p_vs = 1; p_de = 0; cyc = 0;
   endtask

   task automatic mon_step();
      cyc++;
      if (p_hs && !hsync) begin
         if (hf_ok) check("hsync period", 32'(cyc - hf_t), 32'(HT * CD));
         if (de_ok) check("de rise to hsync fall", 32'(cyc - de_t), 32'((HA + HFP) * CD));
         hf_t = cyc; hf_ok = 1; de_ok = 0;
      end
      if (!p_hs && hsync && hf_ok) check("hsync low width", 32'(cyc - hf_t), 32'(HS * CD));
      if (p_vs && !vsync) begin
         if (vf_ok) check("vsync period", 32'(cyc - vf_t), 32'(FRAME_CLK));
         vf_t = cyc; vf_ok = 1;
      end
      if (!p_vs && vsync && vf_ok) check("vsync low width", 32'(cyc - vf_t), 32'(VS * HT * CD));
      if (frame_start) begin
         if (fs_ok) check("frame_start period", 32'(cyc - fs_t), 32'(FRAME_CLK));
         fs_t = cyc; fs_ok = 1;
      end
      if (!p_de && de) begin
         de_t = cyc; de_ok = 1;
      end
      p_hs = hsync; p_vs = vsync; p_de = de;
   endtask

   // Clock n after reset release: counters hold pixel n/CD, pins show the pixel before it.
   task automatic run_clocks(input int nclk);
      exp_t q[$];
      exp_t e;
      int k, c, h, v, ti;
      logic [31:0] a;
      logic [7:0]  b;
      for (int n = 1; n <= nclk; n++) begin
         @(negedge clk);
         k = n / CD;
         c = n % CD;
         mon_step();
         h = k % HT;
         v = (k / HT) % VT;
         if (c == 0) in_blank = !(h < HA && v < VA);
         if (k >= 1 && q.size() > 0) begin
            e = q[0];
            check($sformatf("pix(%0d,%0d) de/hs/vs/fs/rgb", e.ph, e.pv),
                  {16'h0, de, hsync, vsync, frame_start, vga_r, vga_g, vga_b},
                  {16'h0, e.de, e.hs, e.vs, e.fs && (c == 0), e.rgb});
            if (c == 0 && e.tbl >= 0) begin
               check($sformatf("vec%0d de", e.tbl), {31'h0, de}, {31'h0, vecs[e.tbl].de});
               if (vecs[e.tbl].chk_rgb)
                  check($sformatf("vec%0d rgb", e.tbl), {20'h0, vga_r, vga_g, vga_b},
                        {20'h0, vecs[e.tbl].rgb});
            end
            if (c == CD - 1) void'(q.pop_front());
         end
         if (c == CD - 1) begin
            a = exp_addr(h, v);
            check($sformatf("va at (%0d,%0d)", h, v), va, a);
            ti = find_vec(h, v);
            if (ti >= 0) check($sformatf("vec%0d va", ti), va, vecs[ti].va);
            e.ph  = h;
            e.pv  = v;
            e.de  = (h < HA && v < VA);
            e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
            e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
            e.fs  = (h == 0 && v == 0);
            b     = 8'(word_at(a) >> (8 * a[1:0]));
            e.rgb = e.de ? expand(b) : 12'h000;
            e.tbl = ti;
            q.push_back(e);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " va"},    va, BASE);
      check({tag, " hsync"}, {31'h0, hsync}, 32'h1);
      check({tag, " vsync"}, {31'h0, vsync}, 32'h1);
      check({tag, " de"},    {31'h0, de}, 32'h0);
      check({tag, " rgb"},   {20'h0, vga_r, vga_g, vga_b}, 32'h0);
      check({tag, " frame_start"}, {31'h0, frame_start}, 32'h0);
   endtask

   initial begin
      //          h   v   va            chk  rgb      de
      vecs[0]  = '{0,  0,  32'h100, 1'b1, 12'hFFF, 1'b1};
      vecs[1]  = '{1,  0,  32'h100, 1'b1, 12'hFFF, 1'b1};
      vecs[2]  = '{2,  0,  32'h101, 1'b1, 12'h0F0, 1'b1};
      vecs[3]  = '{3,  0,  32'h101, 1'b1, 12'h0F0, 1'b1};
      vecs[4]  = '{4,  0,  32'h102, 1'b1, 12'hF00, 1'b1};
      vecs[5]  = '{5,  0,  32'h102, 1'b1, 12'hF00, 1'b1};
      vecs[6]  = '{6,  0,  32'h103, 1'b1, 12'h00F, 1'b1};
      vecs[7]  = '{7,  0,  32'h103, 1'b1, 12'h00F, 1'b1};
      vecs[8]  = '{63, 1,  32'h11F, 1'b0, 12'h000, 1'b1};
      vecs[9]  = '{0,  2,  32'h120, 1'b0, 12'h000, 1'b1};
      vecs[10] = '{63, 47, 32'h3FF, 1'b0, 12'h000, 1'b1};
      vecs[11] = '{64, 0,  32'h100, 1'b1, 12'h000, 1'b0};
      vecs[12] = '{64, 1,  32'h120, 1'b1, 12'h000, 1'b0};
      vecs[13] = '{70, 47, 32'h100, 1'b1, 12'h000, 1'b0};
      vecs[14] = '{10, 48, 32'h100, 1'b1, 12'h000, 1'b0};
      vecs[15] = '{79, 54, 32'h100, 1'b1, 12'h000, 1'b0};

      in_blank = 1'b0;
      reset_n  = 1'b0;
      mon_clear();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset_n = 1'b1;

      // Two full frames, then stop while pixel (33,30) of the third frame is current
      run_clocks(CD * (2 * HT * VT + 30 * HT + 33) + 1);
      check("de before mid-frame reset", {31'h0, de}, 32'h1);

      @(posedge clk);
      #1 reset_n = 1'b0;
      #1 check_reset_values("async reset");
      repeat (2) @(negedge clk);
      check_reset_values("held reset");
      in_blank = 1'b0;
      reset_n  = 1'b1;
      mon_clear();
      run_clocks(FRAME_CLK + 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
